// File: rtl/peridot_spiflash_reader_if.sv
// Bus bundle for the SPI-flash bulk reader: CPU-side Avalon-MM slave port
// plus the register port of the byte-level SPI engine.
interface peridot_spiflash_reader_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        ins_irq;
    logic        spi_write;
    logic [31:0] spi_writedata;
    logic [31:0] spi_readdata;

    // slave: the reader block; master: the CPU and SPI engine around it
    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, spi_readdata,
        output avs_readdata, ins_irq, spi_write, spi_writedata
    );
    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, spi_readdata,
        input  avs_readdata, ins_irq, spi_write, spi_writedata
    );
endinterface

// File: rtl/peridot_spiflash_reader.sv
// Autonomous SPI-flash READ sequencer: sends cmd + 24-bit address, clocks in
// N bytes, packs them little-endian into 32-bit words and queues them in a FIFO.
module peridot_spiflash_reader #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] READ_CMD   = 8'h03
) (
    input logic                      csi_clk,
    input logic                      rsi_reset_n,
    peridot_spiflash_reader_if.slave bus
);
    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [6:0] DEPTH_CNT = 7'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_PUSH, S_DESEL} state_e;
    typedef enum logic [1:0] {PH_SEND, PH_GUARD, PH_WAIT} phase_e;

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [23:0]        addr_q, addr_d;
    logic [15:0]        len_q, len_d;
    logic               irqena_q, irqena_d, done_q, done_d;
    logic [16:0]        cnt_q, cnt_d, cnt_inc;
    logic [31:0]        word_q, word_d;
    logic               spi_write_q, spi_write_d;
    logic [31:0]        spi_wdata_q, spi_wdata_d;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [6:0]         count_q, count_d;

    logic busy, wr_addr, wr_len, wr_ctrl, start_req, spi_ready, byte_done;
    logic fifo_full, fifo_empty, push, pop, xfer_end, word_end, send;
    logic [7:0] tx_byte;
    logic unused_bits;

    assign busy       = (state_q != S_IDLE);
    assign wr_addr    = bus.avs_write && (bus.avs_address == 2'd0) && !busy;
    assign wr_len     = bus.avs_write && (bus.avs_address == 2'd1) && !busy;
    assign wr_ctrl    = bus.avs_write && (bus.avs_address == 2'd2);
    assign start_req  = wr_ctrl && bus.avs_writedata[0] && !busy;
    assign spi_ready  = bus.spi_readdata[9];
    assign byte_done  = (phase_q == PH_WAIT) && spi_ready;
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == 7'd0);
    assign push       = (state_q == S_PUSH) && !fifo_full;
    assign pop        = bus.avs_read && (bus.avs_address == 2'd3) && !fifo_empty;
    assign cnt_inc    = cnt_q + 17'd1;
    assign xfer_end   = (cnt_q == {1'b0, len_q});
    assign word_end   = (cnt_inc[1:0] == 2'b00) || (cnt_inc == {1'b0, len_q});
    assign unused_bits = ^{bus.spi_readdata[31:10], bus.spi_readdata[8], bus.avs_writedata[31:24]};

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_SEND;
            addr_q      <= '0;
            len_q       <= '0;
            irqena_q    <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            word_q      <= '0;
            spi_write_q <= 1'b0;
            spi_wdata_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            irqena_q    <= irqena_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            spi_write_q <= spi_write_d;
            spi_wdata_q <= spi_wdata_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: FIFO storage has no reset; occupancy is tracked by count_q, which is reset.
    always_ff @(posedge csi_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= word_q;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: if (start_req && (len_q != 16'd0)) begin
                state_d = S_CMD;
                phase_d = PH_SEND;
            end
            S_PUSH: if (!fifo_full) begin
                state_d = xfer_end ? S_DESEL : S_DATA;
                phase_d = PH_SEND;
            end
            default: begin
                case (phase_q)
                    PH_SEND:  phase_d = PH_GUARD;
                    PH_GUARD: phase_d = PH_WAIT;
                    default: if (spi_ready) begin
                        phase_d = PH_SEND;
                        case (state_q)
                            S_CMD:   state_d = S_A2;
                            S_A2:    state_d = S_A1;
                            S_A1:    state_d = S_A0;
                            S_A0:    state_d = S_DATA;
                            S_DATA:  state_d = word_end ? S_PUSH : S_DATA;
                            default: state_d = S_IDLE;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_CMD:   tx_byte = READ_CMD;
            S_A2:    tx_byte = addr_q[23:16];
            S_A1:    tx_byte = addr_q[15:8];
            S_A0:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'hFF;
        endcase
        send        = (phase_q == PH_SEND) && (state_q != S_IDLE) && (state_q != S_PUSH);
        spi_write_d = send;
        spi_wdata_d = spi_wdata_q;
        if (send) spi_wdata_d = (state_q == S_DESEL) ? 32'h0 : {22'b0, 1'b1, 1'b1, tx_byte};

        addr_d   = wr_addr ? bus.avs_writedata[23:0] : addr_q;
        len_d    = wr_len  ? bus.avs_writedata[15:0] : len_q;
        irqena_d = wr_ctrl ? bus.avs_writedata[15]   : irqena_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        if (wr_ctrl && bus.avs_writedata[1]) done_d = 1'b0;
        if (start_req) begin
            done_d = (len_q == 16'd0);
            cnt_d  = '0;
            word_d = '0;
        end
        if ((state_q == S_DATA) && byte_done) begin
            cnt_d = cnt_inc;
            word_d[{cnt_q[1:0], 3'b000} +: 8] = bus.spi_readdata[7:0];
        end
        // Clearing after each push leaves a short final word zero-padded.
        if (push) word_d = '0;
        if ((state_q == S_DESEL) && byte_done) done_d = 1'b1;
    end

    always_comb begin
        bus.avs_readdata = 32'h0;
        case (bus.avs_address)
            2'd0:    bus.avs_readdata = {8'h0, addr_q};
            2'd1:    bus.avs_readdata = {16'h0, len_q};
            2'd2:    bus.avs_readdata = {9'b0, count_q, irqena_q, 13'b0, done_q, busy};
            default: if (!fifo_empty) bus.avs_readdata = fifo_mem[rd_ptr_q];
        endcase
    end

    assign bus.ins_irq       = irqena_q & done_q;
    assign bus.spi_write     = spi_write_q;
    assign bus.spi_writedata = spi_wdata_q;
endmodule

// File: tb/tb_peridot_spiflash_reader.sv
// Randomized bench: a flash/SPI-engine model answers the byte stream, and the
// expected command stream and FIFO words are derived from the flash contents.
module tb_peridot_spiflash_reader;
    logic csi_clk = 1'b0;
    logic rsi_reset_n = 1'b0;
    peridot_spiflash_reader_if bus ();

    peridot_spiflash_reader #(.FIFO_DEPTH(8), .READ_CMD(8'h03)) dut (
        .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n), .bus(bus)
    );

    always #5 csi_clk = ~csi_clk;

    int n_pass = 0, n_checks = 0, n_writes = 0;
    logic [31:0] exp_tx[$], exp_fifo[$];
    logic [23:0] f_base = '0;
    logic [7:0]  f_seed = '0, f_step = 8'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Flash contents: an arithmetic progression anchored at f_base.
    function automatic logic [7:0] fb(input logic [23:0] a);
        logic [23:0] d;
        logic [15:0] p;
        d = a - f_base;
        p = f_step * d[7:0];
        return f_seed + p[7:0];
    endfunction

    task automatic expect_xfer(input logic [23:0] a, input int len);
        logic [31:0] w;
        exp_tx.push_back(32'h0000_0303);
        exp_tx.push_back({24'h000003, a[23:16]});
        exp_tx.push_back({24'h000003, a[15:8]});
        exp_tx.push_back({24'h000003, a[7:0]});
        for (int i = 0; i < len; i++) exp_tx.push_back(32'h0000_03FF);
        exp_tx.push_back(32'h0);
        w = '0;
        for (int i = 0; i < len; i++) begin
            w[8*(i%4) +: 8] = fb(a + 24'(i));
            if ((i % 4 == 3) || (i == len - 1)) begin
                exp_fifo.push_back(w);
                w = '0;
            end
        end
    endtask

    // SPI engine + flash model, and the single compare point for the command stream.
    logic       spi_ready = 1'b1, rx_fresh = 1'b0;
    logic [7:0] spi_rx = '0, next_rx = '0;
    logic [23:0] faddr = '0;
    int busy_left = 0, pos = 0;
    initial begin
        bus.spi_readdata = {22'b0, 1'b1, 9'b0};
        forever begin
            @(negedge csi_clk);
            if (!rsi_reset_n) begin
                spi_ready = 1'b1; busy_left = 0; pos = 0; rx_fresh = 1'b0;
            end else if (bus.spi_write) begin
                n_writes++;
                if (exp_tx.size() > 0) check("spi_tx", bus.spi_writedata, exp_tx.pop_front());
                else begin
                    n_checks++;
                    $display("FAIL spi_tx_unexpected: got write 0x%08h, required no write", bus.spi_writedata);
                end
                if (bus.spi_writedata[8]) begin
                    case (pos)
                        1: faddr[23:16] = bus.spi_writedata[7:0];
                        2: faddr[15:8]  = bus.spi_writedata[7:0];
                        3: faddr[7:0]   = bus.spi_writedata[7:0];
                        default: ;
                    endcase
                    next_rx = (pos >= 4) ? fb(faddr + 24'(pos - 4)) : 8'h00;
                    pos++;
                end else pos = 0;
                spi_ready = 1'b0;
                busy_left = $urandom_range(1, 4);
            end else if (!spi_ready) begin
                busy_left--;
                if (busy_left == 0) begin
                    spi_ready = 1'b1; spi_rx = next_rx; rx_fresh = 1'b1;
                end
            end else if (rx_fresh) begin
                rx_fresh = 1'b0;
                spi_rx = 8'($urandom);
            end
            bus.spi_readdata = {22'b0, spi_ready, 1'b0, spi_rx};
        end
    end

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge csi_clk); #1;
        bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
        @(posedge csi_clk); #1;
        bus.avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge csi_clk); #1;
        bus.avs_address = a; bus.avs_read = 1'b1;
        #2 d = bus.avs_readdata;
        @(posedge csi_clk); #1;
        bus.avs_read = 1'b0;
    endtask

    task automatic read_fifo_chk(input string name, output logic [31:0] d);
        logic [31:0] e;
        avs_rd(2'd3, d);
        e = (exp_fifo.size() > 0) ? exp_fifo.pop_front() : 32'h0;
        check(name, d, e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < budget && s[0]; i++) avs_rd(2'd2, s);
        if (s[0]) begin
            n_checks++;
            $display("FAIL %s: still busy after %0d polls, required idle", name, budget);
        end
    endtask

    task automatic start_xfer(input logic [23:0] a, input int len, input logic irq);
        avs_wr(2'd0, {8'h0, a});
        avs_wr(2'd1, 32'(len));
        expect_xfer(a, len);
        avs_wr(2'd2, {16'h0, irq, 14'h0, 1'b1});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] s, d;
        logic [23:0] a;
        int l, w0, got;
        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;

        // Reset state
        repeat (3) @(posedge csi_clk);
        #1;
        check("rst_spi_write", 32'(bus.spi_write), 32'h0);
        check("rst_spi_wdata", bus.spi_writedata, 32'h0);
        check("rst_irq", 32'(bus.ins_irq), 32'h0);
        for (int r = 0; r < 4; r++) begin
            bus.avs_address = 2'(r); #1;
            check("rst_reg", bus.avs_readdata, 32'h0);
        end
        @(negedge csi_clk) rsi_reset_n = 1'b1;

        // Test 1: 8 bytes from 0x123456 answering 01..08
        f_base = 24'h123456; f_seed = 8'h01; f_step = 8'h01;
        start_xfer(24'h123456, 8, 1'b0);
        bus.avs_address = 2'd2; #1;
        check("t1_busy_rise", 32'(bus.avs_readdata[0]), 32'h1);
        check("t1_no_write_yet", 32'(bus.spi_write), 32'h0);
        @(posedge csi_clk); #1;
        check("t1_first_write", 32'(bus.spi_write), 32'h1);
        wait_idle("t1_idle", 400);
        avs_rd(2'd2, s);
        check("t1_done_busy", {30'b0, s[1:0]}, 32'h2);
        check("t1_count", 32'(s[22:16]), 32'h2);
        read_fifo_chk("t1_word0_model", d);
        check("t1_word0", d, 32'h04030201);
        read_fifo_chk("t1_word1_model", d);
        check("t1_word1", d, 32'h08070605);
        check("t1_tx_left", 32'(exp_tx.size()), 32'h0);

        // Test 2: 5 bytes AA..EE, padded final word
        f_base = 24'h000100; f_seed = 8'hAA; f_step = 8'h11;
        start_xfer(24'h000100, 5, 1'b0);
        wait_idle("t2_idle", 400);
        avs_rd(2'd2, s);
        check("t2_count", 32'(s[22:16]), 32'h2);
        read_fifo_chk("t2_word0_model", d);
        check("t2_word0", d, 32'hDDCCBBAA);
        read_fifo_chk("t2_word1_model", d);
        check("t2_word1", d, 32'h000000EE);

        // Zero length with irqena
        avs_wr(2'd2, 32'h0000_8000);
        avs_wr(2'd1, 32'h0);
        w0 = n_writes;
        avs_wr(2'd2, 32'h0000_8001);
        bus.avs_address = 2'd2; #1;
        check("z_no_busy", 32'(bus.avs_readdata[0]), 32'h0);
        @(posedge csi_clk); #1;
        check("z_irq", 32'(bus.ins_irq), 32'h1);
        repeat (10) @(posedge csi_clk);
        check("z_no_writes", 32'(n_writes), 32'(w0));
        avs_wr(2'd2, 32'h0000_8002);
        #1 check("z_irq_clear", 32'(bus.ins_irq), 32'h0);

        // Start and address writes while busy are ignored
        f_base = 24'h0A0000; f_seed = 8'($urandom); f_step = 8'h03;
        start_xfer(24'h0A0000, 6, 1'b1);
        avs_wr(2'd0, 32'h0077_7777);
        avs_wr(2'd2, 32'h0000_8001);
        wait_idle("b_idle", 400);
        repeat (20) @(posedge csi_clk);
        check("b_tx_left", 32'(exp_tx.size()), 32'h0);
        avs_rd(2'd0, s);
        check("b_addr_kept", s, 32'h000A0000);
        read_fifo_chk("b_word0", d);
        read_fifo_chk("b_word1", d);
        avs_rd(2'd3, d);
        check("b_empty_read", d, 32'h0);
        avs_rd(2'd2, s);
        check("b_empty_count", 32'(s[22:16]), 32'h0);

        // Reset asserted during A1, then a fresh full transfer
        f_base = 24'h200000; f_seed = 8'h40; f_step = 8'h07;
        w0 = n_writes;
        start_xfer(24'h200000, 8, 1'b1);
        for (int i = 0; i < 200 && n_writes < w0 + 3; i++) @(posedge csi_clk);
        if (n_writes < w0 + 3) begin
            n_checks++;
            $display("FAIL r_reach_a1: got %0d writes, required %0d", n_writes - w0, 3);
        end
        #2 rsi_reset_n = 1'b0;
        exp_tx.delete(); exp_fifo.delete();
        #1;
        check("r_spi_write", 32'(bus.spi_write), 32'h0);
        check("r_spi_wdata", bus.spi_writedata, 32'h0);
        check("r_irq", 32'(bus.ins_irq), 32'h0);
        bus.avs_address = 2'd0; #1;
        check("r_addr", bus.avs_readdata, 32'h0);
        bus.avs_address = 2'd2; #1;
        check("r_ctrl", bus.avs_readdata, 32'h0);
        repeat (2) @(posedge csi_clk);
        @(negedge csi_clk) rsi_reset_n = 1'b1;
        start_xfer(24'h200000, 8, 1'b0);
        wait_idle("r_idle", 400);
        read_fifo_chk("r_word0", d);
        read_fifo_chk("r_word1", d);
        check("r_tx_left", 32'(exp_tx.size()), 32'h0);

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            a = 24'($urandom);
            l = $urandom_range(1, 13);
            f_base = a - 24'($urandom_range(0, 3));
            f_seed = 8'($urandom); f_step = 8'($urandom_range(1, 255));
            start_xfer(a, l, 1'($urandom));
            wait_idle("rand_idle", 600);
            avs_rd(2'd2, s);
            check("rand_done", 32'(s[1]), 32'h1);
            check("rand_count", 32'(s[22:16]), 32'((l + 3) / 4));
            for (int k = 0; k < (l + 3) / 4; k++) read_fifo_chk("rand_word", d);
            check("rand_tx_left", 32'(exp_tx.size()), 32'h0);
        end

        // FIFO-full stall: 40 bytes into an 8-word FIFO
        f_base = 24'h345600; f_seed = 8'($urandom); f_step = 8'h05;
        start_xfer(24'h345600, 40, 1'b0);
        s = '0;
        for (int i = 0; i < 2000 && s[22:16] != 7'd8; i++) avs_rd(2'd2, s);
        check("stall_reach_full", 32'(s[22:16]), 32'h8);
        repeat (40) @(posedge csi_clk);
        w0 = n_writes;
        repeat (30) @(posedge csi_clk);
        check("stall_no_tx", 32'(n_writes), 32'(w0));
        avs_rd(2'd2, s);
        check("stall_count", 32'(s[22:16]), 32'h8);
        check("stall_busy", 32'(s[0]), 32'h1);
        check("stall_select", 32'(bus.spi_writedata[8]), 32'h1);
        got = 0;
        for (int i = 0; i < 3000 && got < 10; i++) begin
            avs_rd(2'd2, s);
            if (s[22:16] != 7'd0) begin
                read_fifo_chk("stall_word", d);
                got++;
            end
        end
        check("stall_words", 32'(got), 32'd10);
        wait_idle("stall_idle", 400);
        check("stall_tx_left", 32'(exp_tx.size()), 32'h0);
        check("stall_fifo_left", 32'(exp_fifo.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/peridot_spiflash_reader.md
# peridot_spiflash_reader

Autonomous SPI-Flash bulk-read sequencer for the PERIDOT boot flash. It sits between the CPU's Avalon-MM bus and the byte-level boot SPI engine's register port (start/ready, select, tx/rx byte). It issues a READ (0x03) command with a 24-bit address, clocks out N data bytes and packs them little-endian into 32-bit words. The words go into a small FIFO that the CPU drains, so the CPU no longer has to hand-sequence every byte.

## Interface
- FIFO_DEPTH, 8, data FIFO depth in 32-bit words; power of two, 2..64
- READ_CMD, 8'h03, flash command byte sent first
- csi_clk  in  1  the single clock; all logic on its rising edge
- rsi_reset_n  in  1  reset, asynchronous and active-low
- avs_address  in  2  0 = flash address, 1 = length, 2 = control/status, 3 = data FIFO
- avs_read  in  1  read strobe; one cycle per access
- avs_readdata  out  32  combinational from avs_address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- ins_irq  out  1  equals irqena AND done
- spi_write  out  1  one-cycle write strobe to the SPI engine register
- spi_writedata  out  32  {22'b0, start, select, txbyte}
- spi_readdata  in  32  SPI engine register: bit9 ready, bit7-0 rxbyte

## Operation
- Register map:
  - reg0: bit23-0 flash address, RW.
  - reg1: bit15-0 byte length, RW.
  - reg2: bit0 start(W)/busy(R); bit1 done (R, write 1 clears); bit15 irqena (RW); bit22-16 FIFO count (R).
  - reg3: read returns the FIFO head and pops one word. If the FIFO is empty, the read returns 0 and does not pop.
- Writing reg0 or reg1 while busy has no effect. Writing start=1 while busy is ignored.
- Start with length 0: done is set on the next cycle, busy never asserts, and the SPI engine sees no writes.
- State machine:
  - IDLE: on start with length≠0, latch address and length, clear done, go to CMD.
  - CMD → A2 → A1 → A0: send READ_CMD, then address bits 23-16, 15-8, 7-0.
  - DATA: send 0xFF and capture rxbyte. Repeat until length bytes have been received.
  - PUSH: write the assembled word into the FIFO.
  - DESEL: one write with start=0 and select=0, so the chip-select deasserts.
  - IDLE: set done.
- Every byte-send state:
  - Cycle 1: spi_write=1, writedata = {start=1, select=1, byte}.
  - Cycle 2: guard cycle; ready is ignored.
  - Then wait until ready=1 before moving on.
- In DATA, rxbyte is sampled in the first cycle that ready=1. Byte k of the transfer goes to word bits [8*(k mod 4)+7 : 8*(k mod 4)].
- PUSH is entered after the 4th byte of a word, or after the last byte of the transfer.
- A final partial word has its unused upper bytes set to 0x00.
- If the FIFO is full, the block stays in PUSH and select stays asserted; the flash simply sees SCLK pause. Once the FIFO has room, the word is pushed. The next state is DATA if bytes remain, otherwise DESEL.
- Push and pop in the same cycle, with the FIFO neither full nor empty: the count is unchanged and data order is preserved.
- Push eligibility is based on the registered count; a pop in the same cycle does not make a full FIFO eligible.
- FIFO pointers wrap modulo FIFO_DEPTH. Starting a new transfer does not flush leftover words.
- Byte counter is 17 bits, so length 65535 completes without wrap.

## Timing
- All outputs at reset are 0:
  - spi_write=0, spi_writedata=0
  - ins_irq=0, busy=0, done=0, irqena=0
  - address=0, length=0
  - FIFO empty, count=0
- An asserted reset mid-transfer returns the block to IDLE immediately, without a DESEL write. The SPI engine shares this reset, so its select clears too.
- busy rises in the cycle after the start write. The first spi_write occurs 1 cycle after that.
- Per-byte overhead is 2 cycles plus the SPI engine's busy time. PUSH costs 1 cycle when the FIFO is not full.
- done and ins_irq assert in the cycle after the DESEL byte's ready returns. busy falls in that same cycle.
- avs_readdata is valid in the same cycle as the read. The FIFO pop takes effect on the next clock edge.

## Test plan
- Address 0x123456, length 8, SPI model answers bytes 0x01..0x08 → txbytes are 03,12,34,56,FF×8, then a DESEL write. FIFO holds 0x04030201 and 0x08070605. done=1, busy=0.
- Length 5, bytes 0xAA..0xEE → FIFO holds 0xDDCCBBAA and 0x000000EE. count=2.
- FIFO_DEPTH=8, length 40, CPU does not read → the block stalls in PUSH with count=8 and select still asserted. Draining 1 word resumes transfer. All 10 words arrive in order, and no txbyte is issued while stalled.
- Start with length 0 and irqena=1 → ins_irq=1 two cycles after the write, with zero spi_write pulses. Writing 1 to done clears ins_irq.
- Start written again while busy, and reg0 rewritten while busy → both are ignored and the transfer uses the original address. A reg3 read on an empty FIFO returns 0 and count stays 0.
- rsi_reset_n pulsed low during A1 → all outputs go to 0 asynchronously and the block returns to IDLE. A new start afterward runs the full sequence from CMD.
